ahb_mem_slave: RTL and testbench

- AHB-Lite memory slave: the responder end of the slave-to-master response path. It drives the hrdata / hreadyout / hresp triplet that the response multiplexer selects between.
- Word-organised internal memory with a programmable number of wait states, byte/halfword/word writes, and a two-cycle ERROR response for illegal accesses.
- Instantiated once per slave slot behind the address decoder.

---
 rtl/ahb_mem_slave.sv | 135 +++++++++++++
 tb/tb_ahb_mem_slave.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ahb_mem_slave                                                      |
// | AHB-Lite word memory slave with wait states and two-cycle ERROR.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ahb_mem_slave #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [1:0]  htrans,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic [31:0] hrdata,
   output logic        hreadyout,
   output logic        hresp
);

   localparam int         c_depth = 2**ADDR_WIDTH;
   localparam logic [3:0] c_wait  = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_DATA = 3'd2,
      S_ERR1 = 3'd3,
      S_ERR2 = 3'd4
   } state_t;

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic [ADDR_WIDTH+1:0] r_addr;
   logic                  r_write;
   logic [1:0]            r_size;
   logic [31:0]           r_mem [c_depth];

   logic                  w_open;
   logic                  w_accept;
   logic                  w_illegal;
   logic [3:0]            w_lanes;
   logic [ADDR_WIDTH-1:0] w_word;
   logic                  w_unused;

   // A new address phase can only land while this slave is not stalling.
   assign w_open    = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
   assign w_accept  = w_open && hsel && hready && htrans[1];
   assign w_illegal = ((haddr >> (ADDR_WIDTH + 2)) != 32'd0) ||
                      (hsize > 3'd2) ||
                      ((hsize == 3'd1) && haddr[0]) ||
                      ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
   assign w_word    = r_addr[ADDR_WIDTH+1:2];
   assign w_unused  = &{1'b0, htrans[0]};

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_addr    <= '0;
         r_write   <= 1'b0;
         r_size    <= 2'd0;
         hreadyout <= 1'b1;
         hresp     <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT: begin
               if (r_cnt <= 4'd1) begin
                  r_state   <= S_DATA;
                  hreadyout <= 1'b1;
               end
               r_cnt <= r_cnt - 4'd1;
            end
            S_ERR1: begin
               r_state   <= S_ERR2;
               hreadyout <= 1'b1;
               hresp     <= 1'b1;
            end
            default: begin
               if (w_accept) begin
                  r_addr  <= haddr[ADDR_WIDTH+1:0];
                  r_write <= hwrite;
                  r_size  <= hsize[1:0];
                  if (w_illegal) begin
                     r_state   <= S_ERR1;
                     hreadyout <= 1'b0;
                     hresp     <= 1'b1;
                  end else if (c_wait == 4'd0) begin
                     r_state   <= S_DATA;
                     hreadyout <= 1'b1;
                     hresp     <= 1'b0;
                  end else begin
                     r_state   <= S_WAIT;
                     r_cnt     <= c_wait;
                     hreadyout <= 1'b0;
                     hresp     <= 1'b0;
                  end
               end else begin
                  r_state   <= S_IDLE;
                  hreadyout <= 1'b1;
                  hresp     <= 1'b0;
               end
            end
         endcase
      end
   end

   always_comb begin
      case (r_size)
         2'd0:    w_lanes = 4'b0001 << r_addr[1:0];
         2'd1:    w_lanes = r_addr[1] ? 4'b1100 : 4'b0011;
         default: w_lanes = 4'b1111;
      endcase
   end

   // Writes commit on the edge that closes the final data cycle.
   always_ff @(posedge hclk) begin
      if ((r_state == S_DATA) && r_write) begin
         for (int b = 0; b < 4; b++) begin
            if (w_lanes[b]) begin
               r_mem[w_word][8*b +: 8] <= hwdata[8*b +: 8];
            end
         end
      end
   end

   assign hrdata = (!r_write && ((r_state == S_WAIT) || (r_state == S_DATA))) ?
                   r_mem[w_word] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_slave.sv
`default_nettype none
// Bench for ahb_mem_slave: three instances (0, 1 and 3 wait states) against a
// transfer-level model, with random and directed traffic.
module tb_ahb_mem_slave;

   localparam int AW = 8;
   localparam int NI = 3;

   logic          hclk = 1'b0;
   logic          hresetn;
   logic [NI-1:0] hsel;
   logic [31:0]   haddr;
   logic          hwrite;
   logic [2:0]    hsize;
   logic [1:0]    htrans;
   logic [31:0]   hwdata;
   logic [31:0]   hrdata [NI];
   logic [NI-1:0] hreadyout;
   logic [NI-1:0] hresp;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      ahb_mem_slave #(
         .ADDR_WIDTH (AW),
         .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
      ) u_dut (
         .hclk     (hclk),
         .hresetn  (hresetn),
         .hsel     (hsel[g]),
         .haddr    (haddr),
         .hwrite   (hwrite),
         .hsize    (hsize),
         .htrans   (htrans),
         .hwdata   (hwdata),
         .hready   (hreadyout[g]),
         .hrdata   (hrdata[g]),
         .hreadyout(hreadyout[g]),
         .hresp    (hresp[g])
      );
   end

   always #5 hclk = ~hclk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Transfer-level model: each accepted transfer owns a data phase of known length.
   logic [31:0] m_mem  [NI][256];
   logic [3:0]  m_kn   [NI][256];
   int          m_rem  [NI];
   bit          m_err  [NI];
   bit          m_wr   [NI];
   int          m_word [NI];
   logic [3:0]  m_lanes[NI];
   logic [31:0] m_rval [NI];
   logic [3:0]  m_rkn  [NI];

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      bit          sel;
      logic [1:0]  tr;
      logic [31:0] a;
      bit          w;
      logic [2:0]  s;
      logic [31:0] wd;
   } item_t;

   item_t       xq[$];
   logic [31:0] rq[$];
   int          run_low;

   function automatic int ws_of(int i);
      return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
   endfunction

   function automatic bit illegal(logic [31:0] a, logic [2:0] s);
      return (a[31:AW+2] != 0) || (s > 3'd2) || ((s == 3'd1) && a[0]) ||
             ((s == 3'd2) && (a[1:0] != 2'b00));
   endfunction

   function automatic logic [3:0] lanes_of(logic [31:0] a, logic [2:0] s);
      if (s == 3'd0) return 4'b0001 << a[1:0];
      if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] bytemask(logic [3:0] k);
      return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp, logic [31:0] mask);
      n_cmp++;
      if (((act ^ exp) & mask) !== 32'd0) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (mask %h) at %0t", name, act, exp, mask, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) m_rem[i] = 0;
   endtask

   task automatic model_step();
      bit rdy;
      if (!hresetn) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NI; i++) begin
         rdy = (m_rem[i] <= 1);
         if (m_rem[i] == 1 && !m_err[i] && m_wr[i]) begin
            for (int b = 0; b < 4; b++) begin
               if (m_lanes[i][b]) begin
                  m_mem[i][m_word[i]][8*b +: 8] = hwdata[8*b +: 8];
                  m_kn[i][m_word[i]][b] = 1'b1;
               end
            end
         end
         if (m_rem[i] > 0) m_rem[i]--;
         if (rdy && hsel[i] && htrans[1]) begin
            m_err[i]   = illegal(haddr, hsize);
            m_rem[i]   = m_err[i] ? 2 : ws_of(i) + 1;
            m_wr[i]    = hwrite;
            m_word[i]  = int'(haddr[AW+1:2]);
            m_lanes[i] = lanes_of(haddr, hsize);
            m_rval[i]  = m_mem[i][m_word[i]];
            m_rkn[i]   = m_kn[i][m_word[i]];
         end
      end
   endtask

   task automatic check_outputs();
      bit rd_act;
      for (int i = 0; i < NI; i++) begin
         rd_act = (m_rem[i] > 0) && !m_err[i] && !m_wr[i];
         check($sformatf("hreadyout[%0d]", i), 32'(hreadyout[i]), 32'(m_rem[i] <= 1), 32'd1);
         check($sformatf("hresp[%0d]", i), 32'(hresp[i]), 32'((m_rem[i] > 0) && m_err[i]), 32'd1);
         check($sformatf("hrdata[%0d]", i), hrdata[i], rd_act ? m_rval[i] : 32'd0,
               rd_act ? bytemask(m_rkn[i]) : 32'hFFFF_FFFF);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      model_step();
      @(negedge hclk);
      check_outputs();
   endtask

   // Single non-pipelined transfer; returns final-cycle data/resp and stall count.
   task automatic xfer(int i, logic [31:0] a, bit w, logic [2:0] s, logic [31:0] wd,
                       output logic [31:0] rd, output int low, output bit rsp);
      hsel = '0; hsel[i] = 1'b1; haddr = a; hwrite = w; hsize = s; htrans = 2'b10;
      tick();
      hsel = '0; htrans = 2'b00; haddr = $urandom; hwdata = wd;
      low = 0; rsp = 1'b0; rd = 32'd0;
      for (int k = 0; k < 40; k++) begin
         if (!hreadyout[i]) begin
            low++;
            tick();
         end else begin
            rd  = hrdata[i];
            rsp = hresp[i];
            return;
         end
      end
      n_cmp++; n_fail++;
      $display("FAIL xfer_timeout[%0d]: actual stalled required done within 40 cycles", i);
   endtask

   // Pipelined master: presents the next queued item while the previous data phase runs.
   task automatic run_queue(int i);
      bit          act = 1'b0;
      bit          rd_ph = 1'b0;
      logic [31:0] dwd = 32'd0;
      int          guard = 0;
      run_low = 0;
      while ((xq.size() > 0 || act) && guard < 5000) begin
         hwdata = dwd;
         hsel = '0;
         if (xq.size() > 0) begin
            hsel[i] = xq[0].sel; htrans = xq[0].tr; haddr = xq[0].a;
            hwrite  = xq[0].w;   hsize  = xq[0].s;
         end else begin
            htrans = 2'b00;
         end
         if (!hreadyout[i]) run_low++;
         else begin
            if (act && rd_ph) rq.push_back(hrdata[i]);
            act = 1'b0;
            if (xq.size() > 0) begin
               if (xq[0].sel && xq[0].tr[1]) begin
                  act = 1'b1; rd_ph = !xq[0].w; dwd = xq[0].wd;
               end
               void'(xq.pop_front());
            end
         end
         tick();
         guard++;
      end
      hsel = '0; htrans = 2'b00;
      if (guard >= 5000) begin
         n_cmp++; n_fail++;
         $display("FAIL run_queue_timeout[%0d]: actual %0d cycles required < 5000", i, guard);
      end
   endtask

   function automatic item_t rand_item();
      item_t it;
      int    r;
      it.sel = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 7);
      it.tr = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 5) ? 2'b10 : 2'b11;
      it.s  = 3'($urandom_range(0, 2));
      it.w  = $urandom_range(0, 1) == 1;
      it.wd = $urandom;
      it.a  = 32'($urandom_range(0, 15)) << 2;
      if (it.s == 3'd0) it.a = it.a + 32'($urandom_range(0, 3));
      if (it.s == 3'd1) it.a = it.a + 32'(2 * $urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) begin
         r = $urandom_range(0, 2);
         if (r == 0) it.a = it.a | (32'd1 << $urandom_range(AW + 2, 31));
         else if (r == 1) it.s = 3'($urandom_range(3, 7));
         else begin
            it.s = 3'($urandom_range(1, 2));
            it.a = it.a | 32'd1;
         end
      end
      return it;
   endfunction

   logic [31:0] rd;
   int          low;
   bit          rsp;

   initial begin
      for (int i = 0; i < NI; i++) begin
         m_rem[i] = 0; m_err[i] = 1'b0; m_wr[i] = 1'b0; m_word[i] = 0;
         m_lanes[i] = 4'd0; m_rval[i] = 32'd0; m_rkn[i] = 4'd0;
         for (int w = 0; w < 256; w++) begin
            m_mem[i][w] = 32'd0;
            m_kn[i][w]  = 4'd0;
         end
      end
      hresetn = 1'b0; hsel = '0; haddr = 32'd0; hwrite = 1'b0;
      hsize = 3'd0; htrans = 2'b00; hwdata = 32'd0;
      repeat (3) tick();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("reset_ready[%0d]", i), 32'(hreadyout[i]), 32'd1, 32'd1);
         check($sformatf("reset_resp[%0d]", i), 32'(hresp[i]), 32'd0, 32'd1);
         check($sformatf("reset_rdata[%0d]", i), hrdata[i], 32'd0, 32'hFFFF_FFFF);
      end
      hresetn = 1'b1;
      tick();

      // Selected but IDLE/BUSY: nothing accepted.
      hsel[1] = 1'b1; haddr = 32'h10; htrans = 2'b00;
      repeat (2) tick();
      htrans = 2'b01;
      repeat (2) tick();
      check("idle_sel_ready", 32'(hreadyout[1]), 32'd1, 32'd1);
      hsel = '0; htrans = 2'b00;

      // One wait state.
      xfer(1, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, rd, low, rsp);
      check("ws1_write_stall", 32'(low), 32'd1, 32'hFFFF_FFFF);
      xfer(1, 32'h10, 1'b0, 3'd2, 32'd0, rd, low, rsp);
      check("ws1_read_stall", 32'(low), 32'd1, 32'hFFFF_FFFF);
      check("ws1_read_data", rd, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

      // Sub-word lane merge.
      xfer(1, 32'h20, 1'b1, 3'd2, 32'h1122_3344, rd, low, rsp);
      xfer(1, 32'h22, 1'b1, 3'd0, 32'h00AA_0000, rd, low, rsp);
      xfer(1, 32'h20, 1'b1, 3'd1, 32'h0000_5566, rd, low, rsp);
      xfer(1, 32'h20, 1'b0, 3'd2, 32'd0, rd, low, rsp);
      check("lane_merge", rd, 32'h11AA_5566, 32'hFFFF_FFFF);

      // Error responses leave memory untouched.
      xfer(1, 32'h0, 1'b1, 3'd2, 32'h0102_0304, rd, low, rsp);
      xfer(1, 32'h400, 1'b0, 3'd2, 32'd0, rd, low, rsp);
      check("err_range_stall", 32'(low), 32'd1, 32'hFFFF_FFFF);
      check("err_range_resp", 32'(rsp), 32'd1, 32'd1);
      xfer(1, 32'h2, 1'b1, 3'd2, 32'hFFFF_FFFF, rd, low, rsp);
      check("err_align_resp", 32'(rsp), 32'd1, 32'd1);
      xfer(1, 32'h10, 1'b1, 3'd3, 32'hFFFF_FFFF, rd, low, rsp);
      check("err_size_resp", 32'(rsp), 32'd1, 32'd1);
      xfer(1, 32'h0, 1'b0, 3'd2, 32'd0, rd, low, rsp);
      check("err_mem0_kept", rd, 32'h0102_0304, 32'hFFFF_FFFF);
      xfer(1, 32'h10, 1'b0, 3'd2, 32'd0, rd, low, rsp);
      check("err_mem10_kept", rd, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

      // NONSEQ presented during ERR2.
      xq.push_back('{1'b1, 2'b10, 32'h400, 1'b0, 3'd2, 32'd0});
      xq.push_back('{1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'd0});
      rq.delete();
      run_queue(1);
      check("err2_accept_stalls", 32'(run_low), 32'd2, 32'hFFFF_FFFF);
      check("err2_accept_data", (rq.size() == 2) ? rq[1] : 32'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

      // Zero-wait pipelined burst.
      xq.push_back('{1'b1, 2'b10, 32'h0, 1'b1, 3'd2, 32'hA0A0_0001});
      xq.push_back('{1'b1, 2'b11, 32'h4, 1'b1, 3'd2, 32'hB0B0_0002});
      xq.push_back('{1'b1, 2'b11, 32'h8, 1'b1, 3'd2, 32'hC0C0_0003});
      xq.push_back('{1'b1, 2'b10, 32'h0, 1'b0, 3'd2, 32'd0});
      xq.push_back('{1'b1, 2'b11, 32'h4, 1'b0, 3'd2, 32'd0});
      xq.push_back('{1'b1, 2'b11, 32'h8, 1'b0, 3'd2, 32'd0});
      rq.delete();
      run_queue(0);
      check("burst_stalls", 32'(run_low), 32'd0, 32'hFFFF_FFFF);
      check("burst_rd0", (rq.size() == 3) ? rq[0] : 32'd0, 32'hA0A0_0001, 32'hFFFF_FFFF);
      check("burst_rd1", (rq.size() == 3) ? rq[1] : 32'd0, 32'hB0B0_0002, 32'hFFFF_FFFF);
      check("burst_rd2", (rq.size() == 3) ? rq[2] : 32'd0, 32'hC0C0_0003, 32'hFFFF_FFFF);

      // Three wait states, then reset in the middle of a write.
      xfer(2, 32'h30, 1'b1, 3'd2, 32'hCAFE_F00D, rd, low, rsp);
      check("ws3_write_stall", 32'(low), 32'd3, 32'hFFFF_FFFF);
      hsel = '0; hsel[2] = 1'b1; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
      tick();
      hsel = '0; htrans = 2'b00; hwdata = 32'h1234_5678;
      check("ws3_wait1_ready", 32'(hreadyout[2]), 32'd0, 32'd1);
      @(posedge hclk);
      model_step();
      #2;
      hresetn = 1'b0;
      model_reset();
      #1;
      check("async_reset_ready", 32'(hreadyout[2]), 32'd1, 32'd1);
      check("async_reset_resp", 32'(hresp[2]), 32'd0, 32'd1);
      @(negedge hclk);
      check_outputs();
      hresetn = 1'b1;
      tick();
      xfer(2, 32'h30, 1'b0, 3'd2, 32'd0, rd, low, rsp);
      check("reset_dropped_write", rd, 32'hCAFE_F00D, 32'hFFFF_FFFF);

      // Random pipelined traffic on every instance.
      for (int i = 0; i < NI; i++) begin
         for (int k = 0; k < 250; k++) xq.push_back(rand_item());
         run_queue(i);
         rq.delete();
         repeat (2) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
